farbborg_scan_reader: RTL and testbench
=======================================

# farbborg_scan_reader

Read-side sequencer for the farbborg frame buffer. It walks port B of the 128×64-bit frame RAM (`dualportram_10x8_7x64`), captures each 64-bit word and shifts it serially into the LED driver chain. After each word it latches the data and advances a one-hot row select. It sits between the frame RAM and the cube's shift-register drivers, and is the consumer for the CPU-written pixel data.

## Interface
- `DIV`, default 4: shift-clock divider in `clk` cycles per bit; even, ≥2.
- `clk`  in  1  system clock; frame RAM port B is clocked from it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run scanning; sampled only at word boundaries.
- `addrb`  out  7  frame RAM port B address, registered.
- `dob`  in  64  frame RAM port B data, valid one cycle after `addrb` is sampled.
- `sclk`  out  1  driver shift clock.
- `sdo`  out  1  driver serial data, MSB first.
- `latch`  out  1  driver latch strobe, one cycle.
- `blank`  out  1  driver output blank, active high (`SCAN_BLANK_EN` only; otherwise tied 0).
- `row_sel`  out  8  one-hot row enable.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after word 127 is latched.

## Operation
- `addrb = {plane[3:0], row[2:0]}` gives 16 planes × 8 rows = 128 words per frame.
- **IDLE**
  - If `enable` = 1, go to READ. `addrb` holds its value.
- **READ**
  - `addrb` is stable, and the RAM samples it at the end of this cycle.
  - Next state: LOAD.
- **LOAD**
  - `dob` is valid. `shreg <= dob` at the end of the cycle.
  - Clear the bit counter (6 bits) and the divider counter.
  - Next state: SHIFT.
- **SHIFT**
  - `sdo = shreg[63]`.
  - `sclk` is 0 for the first `DIV/2` cycles of each bit and 1 for the last `DIV/2` cycles.
  - At the end of each bit period, `shreg` shifts left by one.
  - After bit 63's period, go to LATCH. Total time is exactly 64·`DIV` cycles.
- **LATCH**
  - `latch` = 1 for exactly one cycle.
  - On the exit edge, `row_sel <= 1 << addrb[2:0]`, then `addrb <= addrb + 1` (mod 128).
  - If the old `addrb` was 127, pulse `frame_done`.
  - Next state: READ if `enable` = 1, else IDLE.
- **`enable` deassertion**
  - Dropping `enable` mid-word does not abort; the current word completes through LATCH.
- **Address wrap**
  - 127 → 0 with no gap.
  - `frame_done` is asserted in the same cycle as the READ for address 0.
- **Reset (async, any state)**
  - State = IDLE, `addrb` = 0, `sclk` = 0, `sdo` = 0, `latch` = 0, `row_sel` = 0, `busy` = 0, `frame_done` = 0.
  - `blank` = 1 with `SCAN_BLANK_EN`, 0 without.
  - Shift register and counters are cleared.
- **Writer independence**
  - Port-A writes are independent. A byte written to the word currently being shifted appears in the next frame; there is no tearing protection.

## Timing
- Word period is 2 + 64·`DIV` + 1 cycles (READ + LOAD + SHIFT + LATCH); 259 cycles at `DIV` = 4.
- Read latency: `addrb` is valid in READ, `dob` is captured in LOAD, and the first `sdo` bit appears in the first SHIFT cycle.
- `sdo` changes only on `sclk` falling edges (or on entry to SHIFT), giving `DIV/2` cycles of setup before and hold after the rising edge.
- `sclk` is 0 in IDLE, READ, LOAD and LATCH.
- `row_sel` changes only on the LATCH exit edge, one cycle after `latch` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `FARBBORG_SCAN_BLANK_EN`.
- **Defined**
  - `blank` = 1 from the LATCH cycle through the following READ and LOAD, so drivers stay dark while `row_sel` changes.
  - `blank` = 0 during SHIFT.
  - `blank` = 1 in IDLE and in reset.
- **Undefined**
  - `blank` is constant 0.
  - Row changes are unblanked, so ghosting is accepted.

## Test plan
- **Single word:** reset, RAM word 0 = 64'h8000_0000_0000_0001, `enable` = 1 with `DIV` = 4.
  - 64 `sclk` rising edges occur.
  - `sdo` is 1 on the 1st and 64th bits and 0 otherwise.
  - `latch` pulses at cycle 258.
  - `row_sel` = 8'h01 on the next cycle and `addrb` = 1.
- **Frame wrap:** run 128 words.
  - `frame_done` pulses once, as `addrb` goes 127 → 0.
  - `row_sel` cycles 8'h01…8'h80 sixteen times.
- **Stop mid-word:** drop `enable` during bit 20 of word 5.
  - Word 5 completes and latches.
  - The block enters IDLE with `addrb` = 6 and `busy` = 0.
  - Re-enabling resumes at word 6.
- **Async reset mid-SHIFT:** assert `reset_n` = 0 asynchronously while `sclk` = 1.
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - After release and enable, scanning restarts at `addrb` = 0.
- **Concurrent write:** write word 3 via port A while word 3 is shifting.
  - The shifted data equals the old value.
  - The next frame's word 3 equals the new value.
- **`FARBBORG_SCAN_BLANK_EN` defined vs undefined:**
  - Defined: `blank` is 1 exactly during LATCH/READ/LOAD and during IDLE.
  - Undefined: `blank` is always 0.

Source files
------------

// File: rtl/farbborg_scan_reader.sv
// farbborg_scan_reader
//
// Read-side sequencer for the farbborg frame buffer. It walks port B of the
// 128x64 frame RAM one word at a time. For each word it:
//   - issues the address,
//   - captures the returned word,
//   - shifts the word MSB-first into the LED driver chain,
//   - pulses the driver latch,
//   - advances the one-hot row select.
// The address is {plane[3:0], row[2:0]}, so one frame is 16 planes x 8 rows.
//
// Word period: READ + LOAD + 64*DIV SHIFT cycles + LATCH = 3 + 64*DIV cycles.
//
// Parameters
//   DIV         clk cycles per serial bit (even, >= 2)
//
// Ports
//   clk         system clock (frame RAM port B runs on it too)
//   reset_n     asynchronous active-low reset
//   enable      run scanning; only looked at in IDLE and LATCH
//   addrb[6:0]  frame RAM port B address (registered)
//   dob[63:0]   frame RAM port B data, valid one cycle after addrb is sampled
//   sclk        driver shift clock (low half, then high half of each bit)
//   sdo         driver serial data, MSB first
//   latch       one-cycle driver latch strobe
//   blank       driver blank, active high (FARBBORG_SCAN_BLANK_EN only, else 0)
//   row_sel     one-hot row enable, updated as each word is latched
//   busy        high whenever the sequencer is not idle
//   frame_done  one-cycle pulse after word 127 has been latched
//
// Build option
//   FARBBORG_SCAN_BLANK_EN  when defined, blank covers LATCH/READ/LOAD/IDLE
//                           so the drivers stay dark while row_sel moves.
//                           When undefined, blank is tied low.
//
// All outputs come straight from flops. Every output flop is loaded from the
// next-state view, so each output lines up with the state it describes.

module farbborg_scan_reader #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [6:0]  addrb,
  input  logic [63:0] dob,
  output logic        sclk,
  output logic        sdo,
  output logic        latch,
  output logic        blank,
  output logic [7:0]  row_sel,
  output logic        busy,
  output logic        frame_done
);

  localparam int DIVW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(DIV / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  state_t            state_reg, state_next;
  logic [6:0]        addr_reg, addr_next;
  logic [63:0]       shreg_reg, shreg_next;
  logic [5:0]        bit_reg, bit_next;
  logic [DIVW-1:0]   div_reg, div_next;
  logic [7:0]        row_reg, row_next;
  logic              sclk_reg, sclk_next;
  logic              sdo_reg, sdo_next;
  logic              latch_reg, latch_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              blank_reg, blank_next;
  logic [7:0]        row_dec;

  // Row that the word currently addressed belongs to, as a one-hot.
  for (genvar gi = 0; gi < 8; gi++) begin : g_row_dec
    assign row_dec[gi] = (addr_reg[2:0] == 3'(gi));
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    shreg_next = shreg_reg;
    bit_next   = bit_reg;
    div_next   = div_reg;
    row_next   = row_reg;
    done_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_READ;
      end
      // The address register is already stable here; the RAM samples it on
      // the edge that leaves this state.
      ST_READ: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_next = dob;
        bit_next   = '0;
        div_next   = '0;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          shreg_next = {shreg_reg[62:0], 1'b0};
          if (bit_reg == 6'd63) begin
            state_next = ST_LATCH;
          end else begin
            bit_next = bit_reg + 6'd1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      ST_LATCH: begin
        row_next   = row_dec;
        addr_next  = addr_reg + 7'd1;
        done_next  = (addr_reg == 7'd127);
        state_next = enable ? ST_READ : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // sclk is low for the first half of each bit and high for the second.
    // sdo follows the shift register MSB, so it only moves when a bit ends,
    // which is also where sclk falls.
    sclk_next  = (state_next == ST_SHIFT) && (div_next >= DIV_HALF);
    sdo_next   = (state_next == ST_SHIFT) && shreg_next[63];
    latch_next = (state_next == ST_LATCH);
    busy_next  = (state_next != ST_IDLE);
  end

`ifdef FARBBORG_SCAN_BLANK_EN
  localparam logic BLANK_RST = 1'b1;
  assign blank_next = (state_next != ST_SHIFT);
`else
  localparam logic BLANK_RST = 1'b0;
  assign blank_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      shreg_reg <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      row_reg   <= '0;
      sclk_reg  <= 1'b0;
      sdo_reg   <= 1'b0;
      latch_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      blank_reg <= BLANK_RST;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      shreg_reg <= shreg_next;
      bit_reg   <= bit_next;
      div_reg   <= div_next;
      row_reg   <= row_next;
      sclk_reg  <= sclk_next;
      sdo_reg   <= sdo_next;
      latch_reg <= latch_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      blank_reg <= blank_next;
    end
  end

  assign addrb      = addr_reg;
  assign sclk       = sclk_reg;
  assign sdo        = sdo_reg;
  assign latch      = latch_reg;
  assign blank      = blank_reg;
  assign row_sel    = row_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_farbborg_scan_reader.sv
// Bench for farbborg_scan_reader (DIV = 4).
// A behavioural frame RAM drives dob from addrb with one cycle of latency.
// The bench reassembles each shifted word from sdo, sampled on rising sclk.
// Outputs are sampled on the falling clk edge.
module tb_farbborg_scan_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [6:0]  addrb;
  logic [63:0] dob;
  logic        sclk, sdo, latch, blank, busy, frame_done;
  logic [7:0]  row_sel;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [63:0] mem [128];

`ifdef FARBBORG_SCAN_BLANK_EN
  localparam logic BLANK_DARK = 1'b1;
`else
  localparam logic BLANK_DARK = 1'b0;
`endif

  localparam logic [63:0] WORD0 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] NEW3  = 64'hDEAD_BEEF_0BAD_F00D;

  farbborg_scan_reader #(.DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .addrb      (addrb),
    .dob        (dob),
    .sclk       (sclk),
    .sdo        (sdo),
    .latch      (latch),
    .blank      (blank),
    .row_sel    (row_sel),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Frame RAM port B: registered read.
  always @(posedge clk) dob <= mem[addrb];

  always @(negedge clk) if (reset_n && frame_done) done_cnt++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input int i);
    logic [31:0] a, b;
    a = i * 32'h9E37_79B9;
    b = i * 32'h85EB_CA6B;
    return {a, b} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Samples from the next falling edge until latch is seen.
  // Collects sdo at each sclk rise and reports where the latch fell.
  task automatic scan_word(output logic [63:0] w, output int edges, output int lat_idx,
                           output logic bl_shift, output logic bl_latch);
    logic prev;
    bit   seen;
    w = '0; edges = 0; lat_idx = -1; bl_shift = 1'b1; bl_latch = 1'b0;
    prev = sclk; seen = 1'b0;
    for (int idx = 0; idx < 400 && !seen; idx++) begin
      @(negedge clk);
      if (sclk && !prev) begin
        if (edges == 0) bl_shift = blank;
        w = {w[62:0], sdo};
        edges++;
      end
      prev = sclk;
      if (latch) begin
        lat_idx  = idx;
        bl_latch = blank;
        seen     = 1'b1;
      end
    end
    if (!seen) check_val("latch_timeout", 64'd0, 64'd1);
  endtask

  // Scans one word and checks its data, shift timing, blank and the
  // post-latch row/address/frame_done. Ends at the falling edge one cycle
  // after latch.
  task automatic do_word(input int a, input logic [63:0] exp_data, input bit from_idle);
    logic [63:0] w;
    int          edges, lat_idx;
    logic        bl_shift, bl_latch;
    logic [7:0]  exp_row;
    scan_word(w, edges, lat_idx, bl_shift, bl_latch);
    check_val("data", w, exp_data);
    check_val("sclk_edges", 64'(edges), 64'd64);
    check_val("latch_cycle", 64'(lat_idx), from_idle ? 64'd258 : 64'd257);
    check_val("blank_shift", {63'd0, bl_shift}, 64'd0);
    check_val("blank_latch", {63'd0, bl_latch}, {63'd0, BLANK_DARK});
    @(negedge clk);
    exp_row = 8'h01 << (a % 8);
    check_val("row_sel", {56'd0, row_sel}, {56'd0, exp_row});
    check_val("addr_next", {57'd0, addrb}, 64'((a + 1) % 128));
    check_val("frame_done", {63'd0, frame_done}, (a == 127) ? 64'd1 : 64'd0);
    check_val("blank_after", {63'd0, blank}, {63'd0, BLANK_DARK});
    $display("word addr=%0d data=%h row_sel=%h", a, w, row_sel);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_addrb"}, {57'd0, addrb}, 64'd0);
    check_val({tag, "_sclk"}, {63'd0, sclk}, 64'd0);
    check_val({tag, "_sdo"}, {63'd0, sdo}, 64'd0);
    check_val({tag, "_latch"}, {63'd0, latch}, 64'd0);
    check_val({tag, "_row_sel"}, {56'd0, row_sel}, 64'd0);
    check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_val({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    check_val({tag, "_blank"}, {63'd0, blank}, {63'd0, BLANK_DARK});
  endtask

  initial begin
    int   base;
    logic saw_sclk;
    for (int i = 0; i < 128; i++) mem[i] = pattern(i);
    mem[0] = WORD0;

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_val("idle_busy", {63'd0, busy}, 64'd0);

    // Single word from idle, then the rest of the frame.
    // Word 3 is rewritten while it is being shifted.
    base   = done_cnt;
    enable = 1'b1;
    do_word(0, WORD0, 1'b1);
    for (int k = 1; k < 128; k++) begin
      if (k == 3) begin
        fork
          do_word(3, pattern(3), 1'b0);
          begin
            repeat (100) @(negedge clk);
            mem[3] = NEW3;
          end
        join
      end else begin
        do_word(k, mem[k], 1'b0);
      end
    end

    // Second frame: the rewritten word shows up now.
    for (int k = 0; k < 5; k++) do_word(k, mem[k], 1'b0);
    check_val("frame_done_count", 64'(done_cnt - base), 64'd1);

    // Drop enable in bit 20 of word 5; the word still completes.
    fork
      do_word(5, mem[5], 1'b0);
      begin
        repeat (82) @(negedge clk);
        enable = 1'b0;
      end
    join
    check_val("stop_busy", {63'd0, busy}, 64'd0);
    check_val("stop_addr", {57'd0, addrb}, 64'd6);
    repeat (10) @(negedge clk);
    check_val("stop_hold_busy", {63'd0, busy}, 64'd0);
    check_val("stop_hold_addr", {57'd0, addrb}, 64'd6);
    check_val("stop_hold_latch", {63'd0, latch}, 64'd0);
    check_val("stop_hold_blank", {63'd0, blank}, {63'd0, BLANK_DARK});

    enable = 1'b1;
    do_word(6, mem[6], 1'b1);

    // Asynchronous reset while sclk is high, between clock edges.
    saw_sclk = 1'b0;
    for (int t = 0; t < 600 && !saw_sclk; t++) begin
      @(negedge clk);
      saw_sclk = sclk;
    end
    check_val("sclk_high_seen", {63'd0, saw_sclk}, 64'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    reset_n = 1'b1;
    do_word(0, mem[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
